// File: rtl/fwd_scoreboard_pkg.sv
// Shared types for the operand-forwarding scoreboard: default widths,
// register/word typedefs and the operand-source enum used for debug.
package fwd_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] word_t;

    // Where an operand came from this cycle (debug visibility only).
    typedef enum logic [1:0] {
        SRC_RF   = 2'd0,
        SRC_STG  = 2'd1,
        SRC_CMP  = 2'd2,
        SRC_ZERO = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Bundle of operand, pipeline-stage, long-latency and result signals
// between the ID/EX stage (master) and the forwarding scoreboard (slave).
//
// Handshake: iss_valid and cmp_valid are single-cycle valid-only strobes,
// accepted on the rising edge they are high; there is no ready for them.
// stall is the only backpressure: while stall=1 the issuer holds ID/EX and
// earlier stages and must not raise iss_valid.
interface fwd_scoreboard_if
    import fwd_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NSTG = 3,
    parameter int NRD  = 2,
    parameter int CNTW = 16
);
    localparam int AW = $clog2(NREG);

    logic [NRD-1:0][AW-1:0]    rs_idx;
    logic [NRD-1:0][XLEN-1:0]  rs_val;
    logic [NSTG-1:0]           st_regwrite;
    logic [NSTG-1:0]           st_ready;
    logic [NSTG-1:0][AW-1:0]   st_rd;
    logic [NSTG-1:0][XLEN-1:0] st_data;
    logic                      alusrc;
    logic [XLEN-1:0]           imm;
    logic                      id_regwrite;
    logic [AW-1:0]             id_rd;
    logic                      iss_valid;
    logic [AW-1:0]             iss_rd;
    logic                      cmp_valid;
    logic [AW-1:0]             cmp_rd;
    logic [XLEN-1:0]           cmp_data;

    logic [NRD-1:0][XLEN-1:0]  fw_rs;
    logic [XLEN-1:0]           fw_op2;
    logic                      stall;
    logic [NREG-1:0]           pending;
    logic [CNTW-1:0]           stall_cnt;
    fwd_src_e                  dbg_src [NRD];

    modport master (
        output rs_idx, rs_val, st_regwrite, st_ready, st_rd, st_data,
               alusrc, imm, id_regwrite, id_rd, iss_valid, iss_rd,
               cmp_valid, cmp_rd, cmp_data,
        input  fw_rs, fw_op2, stall, pending, stall_cnt, dbg_src
    );

    modport slave (
        input  rs_idx, rs_val, st_regwrite, st_ready, st_rd, st_data,
               alusrc, imm, id_regwrite, id_rd, iss_valid, iss_rd,
               cmp_valid, cmp_rd, cmp_data,
        output fw_rs, fw_op2, stall, pending, stall_cnt, dbg_src
    );

endinterface

// File: rtl/fwd_scoreboard_port_sel.sv
// One read port of the forwarding unit: youngest matching stage wins, then
// the long-latency completion bypass, then the register file. x0 is never
// forwarded and never stalls.
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NSTG = 3
) (
    input  logic [AW-1:0]             rs_idx_i,
    input  logic [XLEN-1:0]           rs_val_i,
    input  logic [NSTG-1:0]           st_regwrite_i,
    input  logic [NSTG-1:0]           st_ready_i,
    input  logic [NSTG-1:0][AW-1:0]   st_rd_i,
    input  logic [NSTG-1:0][XLEN-1:0] st_data_i,
    input  logic                      rs_pending_i,
    input  logic                      cmp_valid_i,
    input  logic [AW-1:0]             cmp_rd_i,
    input  logic [XLEN-1:0]           cmp_data_i,
    output logic [XLEN-1:0]           val_o,
    output logic                      stall_req_o,
    output fwd_src_e                  src_o
);

    logic            hit;
    logic            hit_ready;
    logic [XLEN-1:0] hit_data;

    // Priority search over stages (0 = youngest), then source selection.
    // A not-ready youngest match blocks older stages: their value is stale.
    always_comb begin
        hit         = 1'b0;
        hit_ready   = 1'b0;
        hit_data    = '0;
        val_o       = '0;
        stall_req_o = 1'b0;
        src_o       = SRC_RF;
        for (int i = 0; i < NSTG; i++) begin
            if (!hit && st_regwrite_i[i] && (st_rd_i[i] == rs_idx_i)) begin
                hit       = 1'b1;
                hit_ready = st_ready_i[i];
                hit_data  = st_data_i[i];
            end
        end
        if (rs_idx_i == '0) begin
            src_o = SRC_ZERO;
        end else if (hit) begin
            src_o = SRC_STG;
            if (hit_ready) val_o = hit_data;
            else           stall_req_o = 1'b1;
        end else if (rs_pending_i) begin
            src_o = SRC_CMP;
            if (cmp_valid_i && (cmp_rd_i == rs_idx_i)) val_o = cmp_data_i;
            else                                        stall_req_o = 1'b1;
        end else begin
            val_o = rs_val_i;
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding unit with a scoreboard of registers owned by
// variable-latency ops, load-use / not-ready / WAW stall generation and a
// saturating stalled-cycle counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NSTG = 3,
    parameter int NRD  = 2,
    parameter int CNTW = 16
) (
    input logic              clk,
    input logic              rst_n,
    fwd_scoreboard_if.slave  bus
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0]          pending_q, pending_d;
    logic [CNTW-1:0]          stall_cnt_q, stall_cnt_d;
    logic [NRD-1:0]           port_stall;
    logic [NRD-1:0]           rs_pending;
    logic [NRD-1:0][XLEN-1:0] fw_rs;
    logic                     waw_stall;
    logic                     stall;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        assign rs_pending[p] = pending_q[bus.rs_idx[p]];

        fwd_port_sel #(
            .XLEN (XLEN),
            .AW   (AW),
            .NSTG (NSTG)
        ) u_sel (
            .rs_idx_i      (bus.rs_idx[p]),
            .rs_val_i      (bus.rs_val[p]),
            .st_regwrite_i (bus.st_regwrite),
            .st_ready_i    (bus.st_ready),
            .st_rd_i       (bus.st_rd),
            .st_data_i     (bus.st_data),
            .rs_pending_i  (rs_pending[p]),
            .cmp_valid_i   (bus.cmp_valid),
            .cmp_rd_i      (bus.cmp_rd),
            .cmp_data_i    (bus.cmp_data),
            .val_o         (fw_rs[p]),
            .stall_req_o   (port_stall[p]),
            .src_o         (bus.dbg_src[p])
        );
    end

    // A new destination may not overtake an outstanding long-latency write,
    // unless that write completes in this very cycle.
    assign waw_stall = bus.id_regwrite && (bus.id_rd != '0) && pending_q[bus.id_rd]
                     && !(bus.cmp_valid && (bus.cmp_rd == bus.id_rd));
    assign stall     = (|port_stall) || waw_stall;

    assign bus.fw_rs     = fw_rs;
    assign bus.fw_op2    = bus.alusrc ? bus.imm : fw_rs[1];
    assign bus.stall     = stall;
    assign bus.pending   = pending_q;
    assign bus.stall_cnt = stall_cnt_q;

    // Next scoreboard and counter: completion clears, issue sets (issue wins
    // on the same register), x0 never pending, counter saturates at all-ones.
    always_comb begin
        pending_d = pending_q;
        if (bus.cmp_valid) pending_d[bus.cmp_rd] = 1'b0;
        if (bus.iss_valid && (bus.iss_rd != '0)) pending_d[bus.iss_rd] = 1'b1;
        pending_d[0] = 1'b0;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNTW{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Scoreboard and counter registers; reset discards outstanding ops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Completion must target an outstanding register.
    a_cmp_pending: assert property (@(posedge clk) disable iff (!rst_n)
        bus.cmp_valid |-> pending_q[bus.cmp_rd]);

    // Issuing while the pipeline is held is illegal.
    a_iss_no_stall: assert property (@(posedge clk) disable iff (!rst_n)
        bus.iss_valid |-> !stall);

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed and randomized checks of fwd_scoreboard against a behavioural
// model: operand source rules, stall rules, scoreboard and saturating counter.
module tb_fwd_scoreboard;
    import fwd_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NSTG = 3;
    localparam int NRD  = 2;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NSTG(NSTG), .NRD(NRD), .CNTW(CNTW)) bus ();

    fwd_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NSTG(NSTG), .NRD(NRD), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [NREG-1:0] m_pend = '0;
    int              m_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected operand for port p from the source rules.
    function automatic void ref_port(input int p, output word_t v, output bit st);
        int idx;
        idx = int'(bus.rs_idx[p]);
        v   = '0;
        st  = 1'b0;
        if (idx == 0) return;
        for (int i = 0; i < NSTG; i++) begin
            if (bus.st_regwrite[i] && (int'(bus.st_rd[i]) == idx)) begin
                if (bus.st_ready[i]) v = bus.st_data[i];
                else                 st = 1'b1;
                return;
            end
        end
        if (m_pend[idx]) begin
            if (bus.cmp_valid && (int'(bus.cmp_rd) == idx)) v = bus.cmp_data;
            else                                             st = 1'b1;
            return;
        end
        v = bus.rs_val[p];
    endfunction

    function automatic bit ref_stall();
        bit    s;
        bit    ps;
        word_t v;
        s = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            ref_port(p, v, ps);
            s = s | ps;
        end
        if (bus.id_regwrite && (bus.id_rd != '0) && m_pend[bus.id_rd]
            && !(bus.cmp_valid && (bus.cmp_rd == bus.id_rd)))
            s = 1'b1;
        return s;
    endfunction

    task automatic clear_inputs();
        bus.rs_idx      = '0;
        bus.rs_val      = '0;
        bus.st_regwrite = '0;
        bus.st_ready    = '0;
        bus.st_rd       = '0;
        bus.st_data     = '0;
        bus.alusrc      = 1'b0;
        bus.imm         = '0;
        bus.id_regwrite = 1'b0;
        bus.id_rd       = '0;
        bus.iss_valid   = 1'b0;
        bus.iss_rd      = '0;
        bus.cmp_valid   = 1'b0;
        bus.cmp_rd      = '0;
        bus.cmp_data    = '0;
    endtask

    // Mid-cycle check of the combinational outputs against the model.
    task automatic settle();
        bit    st;
        bit    ps;
        word_t v;
        @(negedge clk);
        st = ref_stall();
        chk("stall", 64'(bus.stall), 64'(st));
        chk("pending", 64'(bus.pending), 64'(m_pend));
        if (!st) begin
            for (int p = 0; p < NRD; p++) begin
                ref_port(p, v, ps);
                chk($sformatf("fw_rs%0d", p), 64'(bus.fw_rs[p]), 64'(v));
            end
        end
        if (bus.alusrc) begin
            chk("fw_op2_imm", 64'(bus.fw_op2), 64'(bus.imm));
        end else if (!st) begin
            ref_port(1, v, ps);
            chk("fw_op2_rs", 64'(bus.fw_op2), 64'(v));
        end
    endtask

    // Advance the model and the DUT by one edge, then check the registers.
    task automatic commit();
        bit st;
        st = ref_stall();
        if (!rst_n) begin
            m_pend = '0;
            m_cnt  = 0;
        end else begin
            if (st && (m_cnt < CMAX)) m_cnt++;
            if (bus.cmp_valid) m_pend[bus.cmp_rd] = 1'b0;
            if (bus.iss_valid && (bus.iss_rd != '0)) m_pend[bus.iss_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("reg_pending", 64'(bus.pending), 64'(m_pend));
        chk("reg_stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    endtask

    initial begin
        int guard;
        int r;
        clear_inputs();

        // Reset state.
        rst_n = 1'b0;
        settle(); commit(); commit();
        chk("rst_pending", 64'(bus.pending), 64'd0);
        chk("rst_cnt", 64'(bus.stall_cnt), 64'd0);
        rst_n = 1'b1;

        // Youngest matching stage wins.
        bus.rs_idx[0] = 5'd5;
        bus.st_regwrite = 3'b011; bus.st_ready = 3'b011;
        bus.st_rd[0] = 5'd5; bus.st_data[0] = 32'h11;
        bus.st_rd[1] = 5'd5; bus.st_data[1] = 32'h22;
        settle();
        chk("youngest_val", 64'(bus.fw_rs[0]), 64'h11);
        chk("youngest_stall", 64'(bus.stall), 64'd0);
        commit();

        // Not-ready youngest match blocks older stage, then clears.
        clear_inputs();
        bus.rs_idx[0] = 5'd7;
        bus.st_regwrite = 3'b011; bus.st_ready = 3'b010;
        bus.st_rd[0] = 5'd7; bus.st_rd[1] = 5'd7; bus.st_data[1] = 32'h77;
        settle();
        chk("notready_stall", 64'(bus.stall), 64'd1);
        commit();
        bus.st_regwrite = 3'b010;
        settle();
        chk("older_val", 64'(bus.fw_rs[0]), 64'h77);
        chk("older_stall", 64'(bus.stall), 64'd0);
        commit();

        // x0 is never forwarded; immediate mux.
        clear_inputs();
        bus.st_regwrite = 3'b001; bus.st_ready = 3'b001;
        bus.st_rd[0] = 5'd0; bus.st_data[0] = 32'hDEAD;
        bus.rs_val[0] = 32'h5; bus.rs_val[1] = 32'h6;
        bus.alusrc = 1'b1; bus.imm = 32'h40;
        settle();
        chk("x0_val0", 64'(bus.fw_rs[0]), 64'd0);
        chk("x0_val1", 64'(bus.fw_rs[1]), 64'd0);
        chk("x0_stall", 64'(bus.stall), 64'd0);
        chk("imm_op2", 64'(bus.fw_op2), 64'h40);
        commit();

        // Long-latency issue, read-while-pending, completion bypass.
        clear_inputs();
        rst_n = 1'b0; commit(); rst_n = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        settle(); commit();
        bus.iss_valid = 1'b0; bus.rs_idx[0] = 5'd9;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("pend_read_stall", 64'(bus.stall), 64'd1);
            commit();
        end
        chk("pend_cnt3", 64'(bus.stall_cnt), 64'd3);
        bus.cmp_valid = 1'b1; bus.cmp_rd = 5'd9; bus.cmp_data = 32'hABCD;
        settle();
        chk("cmp_bypass_val", 64'(bus.fw_rs[0]), 64'hABCD);
        chk("cmp_bypass_stall", 64'(bus.stall), 64'd0);
        commit();
        chk("cmp_cleared", 64'(bus.pending[9]), 64'd0);

        // Same-cycle issue and completion on one register; WAW stall.
        clear_inputs();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
        settle(); commit();
        bus.cmp_valid = 1'b1; bus.cmp_rd = 5'd4;
        settle(); commit();
        chk("iss_wins", 64'(bus.pending[4]), 64'd1);
        clear_inputs();
        bus.id_regwrite = 1'b1; bus.id_rd = 5'd4;
        settle();
        chk("waw_stall", 64'(bus.stall), 64'd1);
        commit();

        // Reset mid-operation discards pending and counter.
        clear_inputs();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        settle(); commit();
        clear_inputs();
        bus.rs_idx[0] = 5'd3;
        guard = 0;
        while ((m_cnt < 10) && (guard < 20)) begin
            settle(); commit();
            guard++;
        end
        chk("pre_rst_cnt", 64'(bus.stall_cnt), 64'd10);
        chk("pre_rst_pend3", 64'(bus.pending[3]), 64'd1);
        rst_n = 1'b0;
        commit();
        chk("mid_rst_pending", 64'(bus.pending), 64'd0);
        chk("mid_rst_cnt", 64'(bus.stall_cnt), 64'd0);
        rst_n = 1'b1;
        bus.rs_val[0] = 32'h333;
        settle();
        chk("post_rst_val", 64'(bus.fw_rs[0]), 64'h333);
        chk("post_rst_stall", 64'(bus.stall), 64'd0);
        commit();

        // Counter saturation.
        clear_inputs();
        bus.st_regwrite = 3'b001; bus.st_ready = 3'b000; bus.st_rd[0] = 5'd1;
        bus.rs_idx[0] = 5'd1;
        for (int k = 0; k < 20; k++) begin
            settle(); commit();
        end
        chk("cnt_saturated", 64'(bus.stall_cnt), 64'(CMAX));

        // Randomized traffic over a small register window for frequent hits.
        clear_inputs();
        rst_n = 1'b0; commit(); rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            for (int p = 0; p < NRD; p++) begin
                bus.rs_idx[p] = 5'($urandom_range(0, 7));
                bus.rs_val[p] = $urandom;
            end
            for (int i = 0; i < NSTG; i++) begin
                bus.st_regwrite[i] = ($urandom_range(0, 2) != 0);
                bus.st_ready[i]    = ($urandom_range(0, 3) != 0);
                bus.st_rd[i]       = 5'($urandom_range(0, 7));
                bus.st_data[i]     = $urandom;
            end
            bus.alusrc      = ($urandom_range(0, 3) == 0);
            bus.imm         = $urandom;
            bus.id_regwrite = ($urandom_range(0, 1) == 1);
            bus.id_rd       = 5'($urandom_range(0, 7));
            r = $urandom_range(1, 7);
            bus.cmp_valid   = m_pend[r] && ($urandom_range(0, 1) == 1);
            bus.cmp_rd      = 5'(r);
            bus.cmp_data    = $urandom;
            bus.iss_valid   = 1'b0;
            bus.iss_rd      = 5'($urandom_range(1, 7));
            if (!ref_stall() && ($urandom_range(0, 2) == 0)) bus.iss_valid = 1'b1;
            settle();
            commit();
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the pipeline operand-forwarding unit; sits between ID/EX register-file read and the ALU operand muxes.
- Selects each source operand from the youngest matching in-flight producer over NSTG pipeline stages, or from a long-latency completion port, or from the register file.
- Keeps a registered scoreboard of destinations owned by variable-latency ops (loads on a wait-state bus, mul/div) and raises a stall when an operand, or a new destination, is unavailable.
- Never forwards x0; adds load-use/not-ready stall generation and a saturating stall counter.

Parameters:
XLEN, 32, data width
NREG, 32, architectural registers; AW = $clog2(NREG)
NSTG, 3, forwarding stages; index 0 = youngest (EX/MEM)
NRD, 2, source-operand read ports; port 1 carries the immediate mux
CNTW, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
rs_idx  in  NRD x AW  source register numbers (ID/EX)
rs_val  in  NRD x XLEN  register-file values
st_regwrite  in  NSTG  stage writes a register
st_ready  in  NSTG  stage result valid (0 for a load still in EX/MEM)
st_rd  in  NSTG x AW  stage destination
st_data  in  NSTG x XLEN  stage result
alusrc  in  1  select imm for port 1 ALU operand
imm  in  XLEN  immediate
id_regwrite  in  1  instruction in ID/EX writes rd
id_rd  in  AW  its destination
iss_valid  in  1  long-latency op issues this cycle
iss_rd  in  AW  its destination
cmp_valid  in  1  long-latency result returns
cmp_rd  in  AW  its destination
cmp_data  in  XLEN  its data
fw_rs  out  NRD x XLEN  forwarded operands
fw_op2  out  XLEN  alusrc ? imm : fw_rs[1]
stall  out  1  hold ID/EX and earlier
pending  out  NREG  scoreboard bits
stall_cnt  out  CNTW  cycles stalled, saturating

Behaviour:
- Operand select, combinational per port p; if rs_idx[p]==0 -> 0, no stall contribution.
- Otherwise: lowest stage i with st_regwrite[i] && st_rd[i]==rs_idx[p] wins.
  - If st_ready[i] -> st_data[i]; else -> stall, and no older stage may be used.
- Else if pending[rs_idx[p]]: cmp_valid && cmp_rd match -> cmp_data; else stall.
- Else rs_val[p] (register file; write-through assumed upstream).
- WAW: stall also when id_regwrite && id_rd!=0 && pending[id_rd] && !(cmp_valid && cmp_rd==id_rd).
- stall = OR of all port stalls and WAW stall. fw_rs values are don't-care while stall=1.
- Scoreboard registers, updated on rising clk:
  - rst_n==0 -> pending=0 and stall_cnt=0; overrides all other updates. Reset mid-operation discards outstanding ops.
  - cmp_valid -> clear pending[cmp_rd].
  - iss_valid && iss_rd!=0 -> set pending[iss_rd]. Set wins when same rd as cmp in the same cycle.
  - pending[0] is constantly 0.
- cmp_valid for a non-pending rd is ignored; assertion flags it. iss_valid while stall=1 is illegal; assertion flags it.
- stall_cnt increments each cycle stall=1 and holds at 2^CNTW-1.
- Latency: operand path 0 cycles; scoreboard visible to operands the cycle after issue/complete; same-cycle cmp is covered by the bypass above.

Decomposition:
- Package fwd_pkg: XLEN/AW defaults, typedefs reg_idx_t and word_t, and an fwd_src_e enum (SRC_RF, SRC_STG, SRC_CMP, SRC_ZERO) used for debug visibility.
- Sub-module fwd_port_sel, one instance per read port: priority search, returning value plus stall_req.
- The scoreboard and counter stay in the top level.

Test Plan:
- rs_idx[0]=5; stage0 rd=5 ready data=0x11; stage1 rd=5 data=0x22 -> fw_rs[0]=0x11, stall=0.
- Stage0 rd=7 st_ready=0; stage1 rd=7 ready -> stall=1; next cycle stage0 retired, stage1 holds rd=7 -> forwards stage1 data, stall=0.
- rs_idx=0 while a stage writes rd=0 with data 0xDEAD -> fw_rs=0, stall=0. Alusrc=1, imm=0x40 -> fw_op2=0x40.
- Issue rd=9, then read rs=9 for 3 cycles -> stall=1 each cycle and stall_cnt=3. On cmp rd=9 data=0xABCD -> fw_rs=0xABCD, stall=0; next cycle pending[9]=0.
- iss_rd=4 and cmp_rd=4 in the same cycle with pending[4]=1 -> pending[4]=1 after the edge. Separately, id_rd=4 while pending -> WAW stall=1.
- pending[3]=1 and stall_cnt=10, assert rst_n=0 for one edge -> pending=0, stall_cnt=0; read rs=3 -> rs_val, stall=0.
